// File: rtl/reg_load_unit.sv
// reg_load_unit: fetches a burst of memory words after a register-load dispatch and
// writes them, row by row, into one buffer register of the operand register file.
// Reports busy/ready and the buffer being filled so the decoder can avoid hazards.
module reg_load_unit #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  localparam int unsigned BufW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned RowW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instruction_ready_reg_load,
  input  logic [3:0]            opcode_function,
  input  logic [BufW-1:0]       buffer_address,
  input  logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  reg_load_stage_ready,
  output logic [BufW-1:0]       current_buffer_loading,
  output logic                  current_buffer_valid,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  reg_wr_en,
  output logic [BufW-1:0]       reg_wr_buf,
  output logic [RowW-1:0]       reg_wr_row,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  load_done,
  output logic                  protocol_error
);

  // Counters are 4 bits wide: the load length never exceeds 15.
  localparam logic [3:0] BurstLen = 4'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [BufW-1:0]       r_buf;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [3:0]            r_len;
  logic [3:0]            r_req_cnt;
  logic [3:0]            r_rsp_cnt;
  logic                  r_wr_en;
  logic [BufW-1:0]       r_wr_buf;
  logic [RowW-1:0]       r_wr_row;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_perr;

  logic [3:0]            w_len;
  logic                  w_dispatch;
  logic                  w_dispatch_err;
  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_outstanding;
  logic                  w_rsp_take;
  logic                  w_rsp_stray;
  logic                  w_last_rsp;
  logic [ADDR_WIDTH-1:0] w_req_addr;

  // Decode the requested length and classify this cycle's handshakes.
  always_comb begin
    w_len = BurstLen;
    if (opcode_function != 4'd0) begin
      w_len = (opcode_function > BurstLen) ? BurstLen : opcode_function;
    end
    w_dispatch     = (r_state == StIdle) && instruction_ready_reg_load;
    w_dispatch_err = (r_state != StIdle) && instruction_ready_reg_load;
    w_req_valid    = (r_state == StLoad) && (r_req_cnt < r_len);
    w_req_fire     = w_req_valid && mem_req_ready;
    // Requests never trail responses, so inequality means one is outstanding.
    w_outstanding  = (r_req_cnt != r_rsp_cnt);
    w_rsp_take     = (r_state == StLoad) && mem_rsp_valid && w_outstanding;
    // Responses in IDLE (e.g. after a reset abort) are silently dropped.
    w_rsp_stray    = (r_state != StIdle) && mem_rsp_valid && !w_outstanding;
    w_last_rsp     = w_rsp_take && (r_rsp_cnt == (r_len - 4'd1));
    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
    w_req_addr     = r_base + ADDR_WIDTH'(r_req_cnt);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and status outputs.
  always_comb begin
    w_state_next           = r_state;
    reg_load_stage_ready   = 1'b0;
    current_buffer_valid   = 1'b0;
    current_buffer_loading = '0;
    load_done              = 1'b0;
    unique case (r_state)
      StIdle: begin
        reg_load_stage_ready = 1'b1;
        if (w_dispatch) w_state_next = StLoad;
      end
      StLoad: begin
        current_buffer_valid   = 1'b1;
        current_buffer_loading = r_buf;
        if (w_last_rsp) w_state_next = StDone;
      end
      StDone: begin
        current_buffer_valid   = 1'b1;
        current_buffer_loading = r_buf;
        load_done              = 1'b1;
        w_state_next           = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Load context, request/response counters, registered row write and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf     <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_wr_en   <= 1'b0;
      r_wr_buf  <= '0;
      r_wr_row  <= '0;
      r_wr_data <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_wr_en <= w_rsp_take;
      if (w_rsp_take) begin
        r_wr_buf  <= r_buf;
        r_wr_row  <= r_rsp_cnt[RowW-1:0];
        r_wr_data <= mem_rsp_data;
      end
      if (w_dispatch) begin
        r_buf     <= buffer_address;
        r_base    <= memory_address;
        r_len     <= w_len;
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end else begin
        if (w_req_fire) r_req_cnt <= r_req_cnt + 4'd1;
        if (w_rsp_take) r_rsp_cnt <= r_rsp_cnt + 4'd1;
      end
      if (w_dispatch_err || w_rsp_stray) r_perr <= 1'b1;
    end
  end

  assign mem_req_valid  = w_req_valid;
  assign mem_req_addr   = w_req_valid ? w_req_addr : '0;
  assign reg_wr_en      = r_wr_en;
  assign reg_wr_buf     = r_wr_buf;
  assign reg_wr_row     = r_wr_row;
  assign reg_wr_data    = r_wr_data;
  assign protocol_error = r_perr;

endmodule

// File: doc/reg_load_unit.md
Name: reg_load_unit

Overview:
- Execution stage directly downstream of the instruction decode FIFO.
- Consumes the one-cycle register-load dispatch pulse and fetches a burst of words from on-chip memory starting at the dispatched memory address.
- Writes the words into the addressed buffer register of the operand register file.
- Reports busy/ready and the buffer currently being filled back to the decoder, so weight loads never target a buffer mid-fill.

Parameters:
- NUM_REGS, 16, number of buffer registers; buffer index width is clog2(NUM_REGS).
- DATA_WIDTH, 64, memory word / register row width.
- ADDR_WIDTH, 16, memory word-address width.
- BURST_LEN, 8, rows per buffer; the default load length (power of two, at most 15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instruction_ready_reg_load  in  1  dispatch pulse from the decoder.
- opcode_function  in  4  load length selector.
- buffer_address  in  clog2(NUM_REGS)  destination buffer.
- memory_address  in  ADDR_WIDTH  base word address.
- reg_load_stage_ready  out  1  idle, can accept a dispatch.
- current_buffer_loading  out  clog2(NUM_REGS)  buffer being filled.
- current_buffer_valid  out  1  current_buffer_loading is meaningful.
- mem_req_valid  out  1  read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH  request word address.
- mem_rsp_valid  in  1  read data valid; in order, always accepted.
- mem_rsp_data  in  DATA_WIDTH  read data.
- reg_wr_en  out  1  register file row write.
- reg_wr_buf  out  clog2(NUM_REGS)  destination buffer.
- reg_wr_row  out  clog2(BURST_LEN)  destination row.
- reg_wr_data  out  DATA_WIDTH  row data.
- load_done  out  1  one-cycle completion pulse.
- protocol_error  out  1  sticky; set when a dispatch arrives while busy.

Behaviour:
Reset:
- All outputs are 0 except reg_load_stage_ready=1.
- State goes to IDLE and all counters clear.
- Reset mid-burst aborts with no load_done. Responses arriving afterwards in IDLE are dropped and produce no write.

States:
- IDLE: ready=1, current_buffer_valid=0.
  - When the dispatch pulse is high, latch buf, base and len, then go to LOAD next cycle.
  - len = BURST_LEN if opcode_function==0; otherwise min(opcode_function, BURST_LEN).
- LOAD: ready=0, current_buffer_valid=1, current_buffer_loading=latched buf.
  - mem_req_valid=1 while req_cnt<len.
  - mem_req_addr = (base+req_cnt) mod 2^ADDR_WIDTH; the address wraps silently.
  - req_cnt increments on valid&&ready.
  - Each mem_rsp_valid in LOAD registers one write on the next cycle: reg_wr_en=1, reg_wr_buf=buf, reg_wr_row=rsp_cnt, reg_wr_data=data. rsp_cnt then increments.
  - Request and response in the same cycle are both processed.
  - When the final response (rsp_cnt==len-1) is received at cycle R, go to DONE.
- DONE (cycle R+1):
  - The final reg_wr_en and load_done=1 occur in the same cycle.
  - current_buffer_valid stays 1.
  - Return to IDLE; reg_load_stage_ready=1 at R+2.

Timing and edge cases:
- Minimum latency: dispatch at T, first request at T+1. With 1-cycle memory, first write at T+3.
- Dispatch in LOAD or DONE: the dispatch is ignored, protocol_error is set (cleared only by rst), and the current load is unaffected.
- mem_rsp_valid while req_cnt==rsp_cnt (no request outstanding): the response is ignored and protocol_error is set.
- mem_req_ready held low: the request stays asserted with a stable address.

Test Plan:
- Dispatch func=0, buf=3, addr=0x0100, 1-cycle memory -> 8 requests at 0x0100..0x0107; writes buf=3 rows 0..7 with matching data; load_done once; ready high 2 cycles after the last response.
- func=3, buf=5, addr=0xFFFE -> requests at 0xFFFE, 0xFFFF, 0x0000; 3 writes, rows 0..2; current_buffer_loading=5 with valid=1 throughout the busy period.
- func=12 with BURST_LEN=8 -> exactly 8 requests (clamped).
- Random mem_req_ready backpressure and 0–4 cycle response latency, func=0 -> address stable while stalled; no lost or duplicated rows; row order 0..7.
- Second dispatch pulse mid-burst -> protocol_error=1; first load completes normally; the second load is never started.
- rst asserted after 4 requests, then late responses arrive -> no reg_wr_en, no load_done; outputs at reset values; a fresh func=0 load afterwards completes normally.
